btn_event_enc: RTL and testbench

Converts debounced button levels into a queue of timestamp-free button events (PRESS, RELEASE, LONG, DOUBLE) for firmware consumption. Sits directly downstream of the per-pin debounce filters and upstream of the PicoRV peripheral bus wrapper, which pops events through a valid/ready port. Replaces polling of raw levels by the CPU; one instance serves all board buttons.

---
 rtl/btn_evt_pkg.sv | 25 ++
 rtl/btn_evt_fifo.sv | 46 ++++
 rtl/btn_event_enc.sv | 174 +++++++++++++++++
 tb/tb_btn_event_enc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event encoder.
// BTN_DCLICK_EN enables the GAP state and DOUBLE events.
package btn_evt_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_DOUBLE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG,
    ST_GAP
  } btn_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Small synchronous FIFO; head is read straight from storage.
// Push and pop may coincide while full.
module btn_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/btn_event_enc.sv
// Turns debounced button levels into a queue of PRESS/RELEASE/LONG/DOUBLE
// events. Define BTN_DCLICK_EN to enable double-click detection.
module btn_event_enc
  import btn_evt_pkg::*;
#(
  parameter int   NUMBTN        = 3,
  parameter logic ACTIVE_LEVEL  = 1'b0,
  parameter int   LONG_CYCLES   = 12_000_000,
  parameter int   DCLICK_CYCLES = 3_000_000,
  parameter int   FIFO_DEPTH    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUMBTN-1:0]            i_btn,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [1+idx_width(NUMBTN):0] o_event,
  output logic                         o_overflow,
  input  logic                         i_clr_ovf
);

  localparam int IDXW = idx_width(NUMBTN);
  localparam int EW   = 2 + IDXW;
  localparam int CW   = cnt_width(LONG_CYCLES, DCLICK_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef BTN_DCLICK_EN
  localparam logic [CW-1:0] GAP_LAST = CW'(DCLICK_CYCLES - 1);
`endif

  logic [NUMBTN-1:0]      pend;
  logic [NUMBTN-1:0]      grant;
  logic [NUMBTN-1:0]      lost;
  logic [NUMBTN-1:0][1:0] code;
  logic [IDXW-1:0]        sel;
  logic [EW-1:0]          head;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign pop     = !empty && i_ready;
  assign push    = (|pend) && (!full || pop);
  assign grant   = push ? (pend & (~pend + 1'b1)) : '0;
  assign o_valid = !empty;
  assign o_event = empty ? '0 : head;

  always_comb begin
    sel = '0;
    for (int i = NUMBTN - 1; i >= 0; i--) begin
      if (pend[i]) sel = IDXW'(i);
    end
  end

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .wdata ({code[sel], sel}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) o_overflow <= 1'b0;
    else       o_overflow <= (|lost) | (o_overflow & ~i_clr_ovf);
  end

  for (genvar i = 0; i < NUMBTN; i++) begin : g_btn
    btn_state_e    st_q;
    btn_state_e    st_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    code_q;
    logic [1:0]    evt_code;
    logic          prev_q;
    logic          pend_q;
    logic          evt;
    logic          on;
    logic          prs;
    logic          rel;

    assign on  = (i_btn[i] == ACTIVE_LEVEL);
    assign prs = on && (prev_q != ACTIVE_LEVEL);
    assign rel = !on && (prev_q == ACTIVE_LEVEL);

    always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      evt      = 1'b0;
      evt_code = EV_PRESS;
      unique case (st_q)
        ST_IDLE: begin
          if (prs) begin
            evt   = 1'b1;
            st_d  = ST_HELD;
            cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (rel) begin
            evt      = 1'b1;
            evt_code = EV_RELEASE;
`ifdef BTN_DCLICK_EN
            st_d     = ST_GAP;
`else
            st_d     = ST_IDLE;
`endif
            cnt_d    = '0;
          end else if (cnt_q == LONG_LAST) begin
            evt      = 1'b1;
            evt_code = EV_LONG;
            st_d     = ST_LONG;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (rel) begin
            evt      = 1'b1;
            evt_code = EV_RELEASE;
            st_d     = ST_IDLE;
          end
        end
`ifdef BTN_DCLICK_EN
        ST_GAP: begin
          // a press landing on the timeout cycle is an ordinary press
          if (prs) begin
            evt      = 1'b1;
            evt_code = (cnt_q < GAP_LAST) ? EV_DOUBLE : EV_PRESS;
            st_d     = ST_HELD;
            cnt_d    = '0;
          end else if (cnt_q >= GAP_LAST) begin
            st_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        st_q   <= ST_IDLE;
        cnt_q  <= '0;
        prev_q <= ~ACTIVE_LEVEL;
        pend_q <= 1'b0;
        code_q <= EV_PRESS;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        prev_q <= i_btn[i];
        // a slot being drained this cycle may take the new event
        if (evt && (!pend_q || grant[i])) begin
          pend_q <= 1'b1;
          code_q <= evt_code;
        end else if (grant[i]) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign lost[i] = evt && pend_q && !grant[i];
    assign pend[i] = pend_q;
    assign code[i] = code_q;
  end

endmodule

// File: tb/tb_btn_event_enc.sv
// Self-checking bench for btn_event_enc against a timestamp-based model.
// Build with or without BTN_DCLICK_EN.
module tb_btn_event_enc;

  localparam int NB = 3;
  localparam int LC = 20;
  localparam int DC = 10;
  localparam int FD = 4;
  localparam int EW = 4;
`ifdef BTN_DCLICK_EN
  localparam bit DCLK = 1'b1;
`else
  localparam bit DCLK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready = 1'b1;
  logic          clr = 1'b0;
  logic [NB-1:0] btn = '1;
  logic          valid;
  logic          ovf;
  logic [EW-1:0] evt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  btn_event_enc #(
    .NUMBTN        (NB),
    .ACTIVE_LEVEL  (1'b0),
    .LONG_CYCLES   (LC),
    .DCLICK_CYCLES (DC),
    .FIFO_DEPTH    (FD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_btn      (btn),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_event    (evt),
    .o_overflow (ovf),
    .i_clr_ovf  (clr)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: timestamps of presses/releases, one pending slot, a queue
  int            cyc = 0;
  bit            held [NB];
  bit            long_done [NB];
  bit            gap_ok [NB];
  int            t_press [NB];
  int            t_rel [NB];
  bit            m_pend [NB];
  logic [1:0]    m_code [NB];
  logic [EW-1:0] q [$];
  bit            m_ovf = 1'b0;

  always @(posedge clk) begin
    bit            pop;
    bit            can;
    bit            drop;
    bit            ev;
    bit            on;
    int            g;
    logic [1:0]    c;
    logic [EW-1:0] item;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        held[i] = 0; long_done[i] = 0; gap_ok[i] = 0; m_pend[i] = 0;
      end
      q.delete();
      m_ovf = 0;
    end else begin
      pop  = (q.size() > 0) && ready;
      can  = (q.size() < FD) || pop;
      g    = -1;
      item = '0;
      for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) g = i;
      if (!can) g = -1;
      if (g >= 0) item = {m_code[g], 2'(g)};
      drop = 0;
      for (int i = 0; i < NB; i++) begin
        on = (btn[i] == 1'b0);
        ev = 0;
        c  = 2'd0;
        if (on && !held[i]) begin
          held[i] = 1; long_done[i] = 0; t_press[i] = cyc; ev = 1;
          c = (DCLK && gap_ok[i] && (cyc - t_rel[i] < DC)) ? 2'd3 : 2'd0;
        end else if (!on && held[i]) begin
          held[i] = 0; ev = 1; c = 2'd1;
          gap_ok[i] = !long_done[i];
          t_rel[i] = cyc;
        end else if (on && !long_done[i] && (cyc - t_press[i] == LC)) begin
          long_done[i] = 1; ev = 1; c = 2'd2;
        end
        if (g == i) m_pend[i] = 0;
        if (ev) begin
          if (m_pend[i]) drop = 1;
          else begin m_pend[i] = 1; m_code[i] = c; end
        end
      end
      if (pop) void'(q.pop_front());
      if (g >= 0) q.push_back(item);
      m_ovf = drop | (m_ovf & !clr);
    end
  end

  always @(negedge clk) begin
    bit            ev_v;
    logic [EW-1:0] ev_e;
    if (chk_en) begin
      ev_v = (q.size() > 0);
      ev_e = ev_v ? q[0] : '0;
      check("model_valid", valid, ev_v);
      check("model_event", evt, ev_e);
      check("model_ovf", ovf, m_ovf);
    end
  end

  task automatic wait_evt(input string nm, input logic [EW-1:0] e,
                          input int exp_n);
    int n;
    n = -1;
    for (int k = 1; k <= exp_n + 8; k++) begin
      @(negedge clk);
      if (valid && evt == e) begin
        n = k;
        break;
      end
    end
    check(nm, n, exp_n);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    check("rst_valid", valid, 0);
    check("rst_event", evt, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    settle(2);

    btn[0] = 1'b0; wait_evt("b0_press", 4'h0, 2);
    btn[0] = 1'b1; wait_evt("b0_release", 4'h4, 2);
    settle(30);

    btn[1] = 1'b0; wait_evt("b1_press", 4'h1, 2);
    wait_evt("b1_long", 4'h9, LC);
    settle(3);
    btn[1] = 1'b1; wait_evt("b1_release", 4'h5, 2);
    settle(1);
    btn[1] = 1'b0; wait_evt("b1_repress", 4'h1, 2);
    btn[1] = 1'b1; wait_evt("b1_rerelease", 4'h5, 2);
    settle(30);

`ifdef BTN_DCLICK_EN
    btn[0] = 1'b0; wait_evt("dc_press", 4'h0, 2);
    btn[0] = 1'b1; wait_evt("dc_release", 4'h4, 2);
    settle(3);
    btn[0] = 1'b0; wait_evt("dc_double", 4'hC, 2);
    btn[0] = 1'b1; wait_evt("dc_release2", 4'h4, 2);
    settle(10);
    btn[0] = 1'b0; wait_evt("dc_late_press", 4'h0, 2);
    btn[0] = 1'b1;
    settle(30);
`endif

    btn = 3'b000; wait_evt("all_idx0", 4'h0, 2);
    @(negedge clk); check("all_idx1", evt, 4'h1);
    @(negedge clk); check("all_idx2", evt, 4'h2);
    btn = 3'b111;
    settle(30);

    ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) check("ovf_before_6th", ovf, 0);
      btn[2] = ~btn[2];
      settle(3);
    end
    check("ovf_set", ovf, 1);
    check("ovf_full_valid", valid, 1);
    check("ovf_full_head", evt, 4'h2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_clr", ovf, 0);
    ready = 1'b1;
    @(negedge clk);
    check("drain_2nd", evt, 4'h6);
    settle(30);

    ready = 1'b0;
    btn[2] = 1'b0;
    btn[1] = 1'b0;
    settle(4);
    check("rq_valid", valid, 1);
    rst = 1'b1;
    btn[1] = 1'b1;
    @(negedge clk);
    check("rq_cleared", valid, 0);
    rst = 1'b0;
    ready = 1'b1;
    wait_evt("post_rst_press", 4'h2, 2);
    btn[2] = 1'b1; wait_evt("post_rst_release", 4'h6, 2);
    settle(30);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 40) == 0);
      rst   = ($urandom_range(0, 700) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    ready = 1'b1;
    settle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
